mout_reader: RTL and testbench

- Read-side companion to the conv engine's output-BRAM write path.
- After a layer finishes, the block fetches packed 4x8-bit result words from the output BRAM through the standard BRAM port: en, byte addr, R_data, W_req, W_data.
- It streams the words to the host/DMA side over a valid/ready interface, handling the 1-cycle BRAM read latency with a small credit-managed FIFO.
- It sits between the output BRAM (second port) and the host bridge.

---
 rtl/mout_reader_if.sv | 22 ++
 rtl/mout_reader.sv | 172 +++++++++++++++++
 tb/tb_mout_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mout_reader_if.sv
// mout_reader_if: valid/ready word stream from the output-BRAM reader to the host bridge.
// master drives the words; slave supplies backpressure through m_ready.
interface mout_reader_if;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/mout_reader.sv
// mout_reader: after a conv layer completes, fetches packed 4x8-bit result words from the
// output BRAM (second port) and streams them to the host bridge. A small FIFO absorbs the
// 1-cycle BRAM read latency. A read is only issued while a FIFO slot is guaranteed free, so
// every returning word is captured unconditionally.
// Optional running checksum of streamed words: define MOUT_READER_CKSUM_EN.
module mout_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    output logic             busy,
    output logic             finish,
    output logic             Mo_en,
    output logic [31:0]      Mo_addr,
    input  logic [31:0]      Mo_R_data,
    output logic [3:0]       Mo_W_req,
    output logic [31:0]      Mo_W_data,
`ifdef MOUT_READER_CKSUM_EN
    output logic [31:0]      cksum,
`endif
    mout_reader_if.master    m_if
);

    localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e           state_q;
    logic [29:0]      word_ptr_q;
    logic [CNT_W-1:0] issue_left_q;
    logic [CNT_W-1:0] out_left_q;
    logic             busy_q;
    logic             finish_q;
    logic             inflight_q;

    logic [31:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic [CW-1:0]    credit_used;
    logic             issue;
    logic             push;
    logic             pop;
    logic             last_pop;
    logic             unused_base;

    // Byte offset within a word is meaningless for word-aligned fetches.
    assign unused_base = ^base_addr[1:0];

    // Slots already committed: words buffered plus the read whose data returns this cycle.
    assign credit_used = count_q + CW'(inflight_q);
    assign issue       = (state_q == StRead) && (issue_left_q != '0) && (credit_used < DEPTH_C);
    assign push        = inflight_q;
    assign pop         = m_if.m_valid & m_if.m_ready;
    assign last_pop    = pop && (out_left_q == CNT_W'(1));

    assign busy      = busy_q;
    assign finish    = finish_q;
    assign Mo_en     = issue;
    assign Mo_addr   = {word_ptr_q, 2'b00};
    assign Mo_W_req  = 4'b0000;
    assign Mo_W_data = 32'h0000_0000;

    assign m_if.m_valid = (count_q != '0);
    assign m_if.m_data  = fifo_q[rd_ptr_q];
    assign m_if.m_last  = m_if.m_valid && (out_left_q == CNT_W'(1));

    // Transfer sequencing: latch the request, issue reads under credit, wait for the last pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            word_ptr_q   <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        word_ptr_q   <= base_addr[31:2];
                        issue_left_q <= word_cnt;
                        out_left_q   <= word_cnt;
                        busy_q       <= 1'b1;
                        // An empty request skips the read phase; DRAIN retires it next cycle.
                        state_q      <= (word_cnt != '0) ? StRead : StDrain;
                    end
                end
                StRead: begin
                    if (issue) begin
                        word_ptr_q   <= word_ptr_q + 30'd1;
                        issue_left_q <= issue_left_q - CNT_W'(1);
                        if (issue_left_q == CNT_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                    if (pop) begin
                        out_left_q <= out_left_q - CNT_W'(1);
                    end
                end
                StDrain: begin
                    if (pop) begin
                        out_left_q <= out_left_q - CNT_W'(1);
                    end
                    // finish lands on the cycle right after the final handshake.
                    if (last_pop || (out_left_q == '0)) begin
                        state_q  <= StDone;
                        finish_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output FIFO: capture returning BRAM data, pop on stream handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (push) begin
                fifo_q[wr_ptr_q] <= Mo_R_data;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef MOUT_READER_CKSUM_EN
    // Running sum of delivered words; holds its final value until the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cksum <= '0;
        end else if ((state_q == StIdle) && start) begin
            cksum <= '0;
        end else if (pop) begin
            cksum <= cksum + m_if.m_data;
        end
    end
`else
    // No checksum hardware in this build.
`endif

endmodule

// File: tb/tb_mout_reader.sv
// tb_mout_reader: directed bench for mout_reader with a synchronous-read BRAM model.
module tb_mout_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        finish;
    logic        Mo_en;
    logic [31:0] Mo_addr;
    logic [31:0] Mo_R_data;
    logic [3:0]  Mo_W_req;
    logic [31:0] Mo_W_data;
`ifdef MOUT_READER_CKSUM_EN
    logic [31:0] cksum;
`endif

    mout_reader_if s_if ();

    mout_reader #(
        .FIFO_DEPTH(4),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .busy     (busy),
        .finish   (finish),
        .Mo_en    (Mo_en),
        .Mo_addr  (Mo_addr),
        .Mo_R_data(Mo_R_data),
        .Mo_W_req (Mo_W_req),
        .Mo_W_data(Mo_W_data),
`ifdef MOUT_READER_CKSUM_EN
        .cksum    (cksum),
`endif
        .m_if     (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data appears the cycle after the enable.
    logic [31:0] bram [1024];
    always @(posedge clk) begin
        if (Mo_en) Mo_R_data <= bram[Mo_addr[11:2]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    logic [31:0] got [$];
    logic [31:0] addrs [$];
    int first_valid, last_hs, fin_cyc, n_issue, issue_at_hold;

    // One transfer; m_ready is 0 for `hold` cycles, then follows pat (bit 0 first, repeating).
    // A second start with different parameters is pulsed in cycle restart_at (0 = never).
    task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt,
                            input logic [3:0] pat, input int hold, input int restart_at);
        int          outst;
        logic        stall_prev;
        logic [31:0] prev_data;
        got.delete();
        addrs.delete();
        first_valid = -1; last_hs = -1; fin_cyc = -1; n_issue = 0; issue_at_hold = -1;
        outst = 0; stall_prev = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; base_addr = base; word_cnt = cnt; s_if.m_ready = 1'b0;
        @(negedge clk);
        for (int c = 1; c < 200 && fin_cyc < 0; c++) begin
            start = (c == restart_at);
            if (c == restart_at) begin
                base_addr = 32'h0000_0200;
                word_cnt  = 16'd8;
            end
            s_if.m_ready = (c <= hold) ? 1'b0 : pat[(c - 1 - hold) % 4];
            #1;
            if (finish) fin_cyc = c;
            check32("busy", {31'b0, busy}, finish ? 32'd0 : 32'd1);
            if (Mo_en) begin
                check32("credit", {31'b0, outst < 4}, 32'd1);
                addrs.push_back(Mo_addr);
                n_issue++;
            end
            if (c == hold) issue_at_hold = n_issue;
            if (stall_prev) begin
                check32("stall_valid", {31'b0, s_if.m_valid}, 32'd1);
                check32("stall_data", s_if.m_data, prev_data);
            end
            if (s_if.m_valid) begin
                if (first_valid < 0) first_valid = c;
                check32("m_last", {31'b0, s_if.m_last},
                        (got.size() + 1 == int'(cnt)) ? 32'd1 : 32'd0);
                if (s_if.m_ready) begin
                    got.push_back(s_if.m_data);
                    last_hs = c;
                end
            end
            stall_prev = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            outst      = outst + int'(Mo_en) - int'(s_if.m_valid && s_if.m_ready);
            @(negedge clk);
        end
        start = 1'b0;
        check32("finish_seen", {31'b0, fin_cyc >= 0}, 32'd1);
        #1;
        check32("finish_pulse_len", {31'b0, finish}, 32'd0);
        check32("busy_after", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_seq8(input string tag);
        check32({tag, "_count"}, got.size(), 32'd8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            check32(tag, got[k], 32'(k + 1) * 32'h1111_1111);
        end
    endtask

    int nf, nv;

    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = 32'hDEAD_0000 | 32'(i);
        for (int k = 0; k < 8; k++) bram[64 + k] = 32'(k + 1) * 32'h1111_1111;
        bram[1022] = 32'hA5A5_0001;
        bram[1023] = 32'hA5A5_0002;
        bram[0]    = 32'hA5A5_0003;

        rst = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; s_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_finish", {31'b0, finish}, 32'd0);
        check32("rst_en", {31'b0, Mo_en}, 32'd0);
        check32("rst_valid", {31'b0, s_if.m_valid}, 32'd0);
        check32("rst_last", {31'b0, s_if.m_last}, 32'd0);
        check32("rst_addr", Mo_addr, 32'h0);
        check32("rst_wreq", {28'b0, Mo_W_req}, 32'h0);
        check32("rst_wdata", Mo_W_data, 32'h0);
`ifdef MOUT_READER_CKSUM_EN
        check32("rst_cksum", cksum, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Full-rate burst of 8 words from 0x100.
        run_xfer(32'h0000_0100, 16'd8, 4'b1111, 0, 0);
        check_seq8("t1_data");
        check32("t1_first_valid", 32'(first_valid), 32'd3);
        check32("t1_last_hs", 32'(last_hs), 32'd10);
        check32("t1_finish_cyc", 32'(fin_cyc), 32'd11);
        check32("t1_issues", 32'(n_issue), 32'd8);
        check32("t1_addr0", addrs[0], 32'h0000_0100);
        check32("t1_addr7", addrs[7], 32'h0000_011C);
`ifdef MOUT_READER_CKSUM_EN
        // 0x11111111 * (1+2+...+8) = 0x11111111 * 36, mod 2^32.
        check32("t1_cksum", cksum, 32'h6666_6664);
`endif

        // Backpressure pattern 1,0,0,1.
        run_xfer(32'h0000_0100, 16'd8, 4'b1001, 0, 0);
        check_seq8("t2_data");
        check32("t2_issues", 32'(n_issue), 32'd8);

        // Consumer stalled for 20 cycles: only FIFO_DEPTH reads may go out.
        run_xfer(32'h0000_0100, 16'd8, 4'b1111, 20, 0);
        check32("t3_issue_hold", 32'(issue_at_hold), 32'd4);
        check_seq8("t3_data");

        // Empty request.
        run_xfer(32'h0000_0100, 16'd0, 4'b1111, 0, 0);
        check32("t4_issues", 32'(n_issue), 32'd0);
        check32("t4_words", got.size(), 32'd0);
        check32("t4_finish_cyc", 32'(fin_cyc), 32'd2);

        // Address wrap at the top of the byte address space.
        run_xfer(32'hFFFF_FFF8, 16'd3, 4'b1111, 0, 0);
        check32("t5_issues", 32'(n_issue), 32'd3);
        check32("t5_addr0", addrs[0], 32'hFFFF_FFF8);
        check32("t5_addr1", addrs[1], 32'hFFFF_FFFC);
        check32("t5_addr2", addrs[2], 32'h0000_0000);
        check32("t5_words", got.size(), 32'd3);
        check32("t5_data2", got[2], 32'hA5A5_0003);

        // Start while busy is ignored.
        run_xfer(32'h0000_0100, 16'd4, 4'b1111, 0, 2);
        check32("t6_words", got.size(), 32'd4);
        check32("t6_data3", got[3], 32'h4444_4444);
        check32("t6_issues", 32'(n_issue), 32'd4);

        // Reset after 3 handshakes.
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_0100; word_cnt = 16'd8; s_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check32("t7_pre_busy", {31'b0, busy}, 32'd1);
        check32("t7_pre_valid", {31'b0, s_if.m_valid}, 32'd1);
        check32("t7_pre_data", s_if.m_data, 32'h4444_4444);
        #2;
        rst = 1'b0;
        #1;
        check32("t7_busy", {31'b0, busy}, 32'd0);
        check32("t7_en", {31'b0, Mo_en}, 32'd0);
        check32("t7_valid", {31'b0, s_if.m_valid}, 32'd0);
        check32("t7_last", {31'b0, s_if.m_last}, 32'd0);
        check32("t7_addr", Mo_addr, 32'h0);
        check32("t7_finish", {31'b0, finish}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nf = 0; nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            nf += int'(finish);
            nv += int'(s_if.m_valid);
        end
        check32("t7_no_finish", 32'(nf), 32'd0);
        check32("t7_no_valid", 32'(nv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
